issue_stage: RTL and testbench
==============================

# issue_stage

Registered, parametrised issue stage for the Tomasulo core, sitting between the decoder and the RS/LSB/ROB. It accepts one decoded instruction per cycle through a valid/ready handshake. On acceptance it allocates a ROB entry, reads operands and renames them through the regfile, and holds the instruction in a one-entry issue register. While the entry waits for a free RS/LSB slot, it snoops `CDB_N` broadcast channels so that no wakeup is lost between rename and dispatch.

## Interface
- `XLEN`, 32, data/PC width
- `ROB_W`, 4, ROB tag width (ROB depth = 2^ROB_W)
- `REG_W`, 5, architectural register index width
- `OP_W`, 6, internal opcode width
- `CDB_N`, 2, number of CDB broadcast channels

- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `flush` in 1: mispredict flush, synchronous
- `dec_valid` in 1 / `dec_ready` out 1: decoder handshake
- `dec_pc`, `dec_imm` in XLEN: decoded PC and immediate
- `dec_op` in OP_W; `dec_rd`, `dec_rs1`, `dec_rs2` in REG_W; `dec_is_ls` in 1: decoded fields; `dec_is_ls` = 1 routes to LSB, 0 routes to RS
- `rob_full` in 1; `rob_tag` in ROB_W: next free ROB entry
- `rob_alloc` out 1: ROB allocation pulse
- `rf_rs1`, `rf_rs2` out REG_W = `dec_rs1`, `dec_rs2` (combinational read)
- `rf_vj`, `rf_vk` in XLEN; `rf_qj_busy`, `rf_qk_busy` in 1; `rf_qj`, `rf_qk` in ROB_W: regfile read data
- `ren_we` out 1; `ren_rd` out REG_W; `ren_tag` out ROB_W: rename write to regfile
- `cdb_valid` in CDB_N; `cdb_tag` in CDB_N*ROB_W; `cdb_value` in CDB_N*XLEN: channel i occupies slice i
- `rs_full`, `lsb_full` in 1: target cannot accept this cycle
- `out_valid_rs`, `out_valid_lsb` out 1: dispatch strobes, mutually exclusive
- `out_pc`, `out_imm`, `out_vj`, `out_vk` out XLEN; `out_op` out OP_W; `out_rd` out REG_W; `out_tag`, `out_qj`, `out_qk` out ROB_W; `out_qj_busy`, `out_qk_busy` out 1: dispatch payload
- `stall_rob_cnt`, `stall_disp_cnt` out 32: present only with `ISSUE_PERF_EN`

## Operation
- **State:** `hold_valid` plus the registered entry: pc, op, rd, imm, tag, is_ls, vj, vk, qj, qk, qj_busy, qk_busy.
- **Handshakes:**
  - `disp_fire` = `hold_valid & (is_ls ? !lsb_full : !rs_full)`.
  - `dec_ready` = `!flush & !rob_full & (!hold_valid | disp_fire)`.
  - `accept` = `dec_valid & dec_ready`.
- **On accept:**
  - `rob_alloc` = 1.
  - `ren_we` = `(dec_rd != 0)`, with `ren_rd` = `dec_rd` and `ren_tag` = `rob_tag`.
  - The entry captures `rob_tag` as tag.
- **Operand capture, per operand:**
  - If rs == 0: V = 0, busy = 0.
  - Else if `rf_q*_busy` and some `cdb_valid[i]` has `cdb_tag[i]` == `rf_q*`: V = that `cdb_value`, busy = 0 (capture bypass).
  - Otherwise: regfile values.
- **Hold snoop:** each cycle, a busy operand whose Q matches a valid CDB channel clears busy and loads the value.
- **Dispatch outputs** are the registered entry merged combinationally with the same-cycle CDB match. A dispatch in the cycle of a broadcast therefore carries the forwarded value with busy = 0.
- **Multiple CDB matches:** the lowest channel index wins.
- **`out_valid_rs` / `out_valid_lsb`:** `out_valid_rs` = `hold_valid & !is_ls`; `out_valid_lsb` = `hold_valid & is_ls`. They stay asserted while the target is full. The target samples the payload only when not full.
- **Next state:**
  - `flush` → `hold_valid` = 0.
  - Else `accept` → load the entry (covers simultaneous dispatch and accept).
  - Else `disp_fire` → `hold_valid` = 0.
  - Else hold with snoop updates.
- **Flush:** dominates everything. `dec_ready`, `rob_alloc` and `ren_we` are 0 in the flush cycle, and the held entry is dropped without dispatch.

## Timing
- Latency is 1 cycle: accept at edge N, dispatch strobe asserted from cycle N+1.
- Throughput is 1 instruction/cycle when the target never fills.
- `rob_alloc` and `ren_we` are combinational with `accept`. The ROB and regfile commit them at the same edge.
- **Reset (`rst_n` low, asynchronous):**
  - `hold_valid` = 0.
  - All entry registers = 0.
  - All out_* = 0.
  - Counters = 0.
- `dec_ready` is 1 after reset release (given `!rob_full`, `!flush`).
- Reset mid-hold discards the entry.

## Configuration
- **`ISSUE_PERF_EN` defined:**
  - `stall_rob_cnt` increments each cycle `dec_valid & rob_full & !flush`.
  - `stall_disp_cnt` increments each cycle `hold_valid & !disp_fire & !flush`.
  - Both counters are 32-bit, wrap at 2^32, and are cleared by reset only.
- **`ISSUE_PERF_EN` undefined:** counter ports and logic are absent. Functional behaviour is identical.

## Structure
- The shared package `riscv_pkg` holds:
  - `XLEN`, `ROB_W`, `REG_W`, `OP_W` defaults;
  - `issue_entry_t`, the struct of the held fields;
  - `operand_t` (v, q, busy).
- Sub-module `issue_cdb_match`: CDB_N-way tag compare with lowest-index select, outputs hit and value. There are four instances: j and k capture, j and k hold.

## Test plan
- **Reset:** drive `rst_n` low while `hold_valid` = 1 → all out_* = 0 immediately, `dec_ready` = 1 after release, counters = 0.
- **Basic RS issue:** add rd=3, rs1=1, rs2=2, `rf_vj` = 5, `rf_vk` = 7, not busy, `rob_tag` = 3 →
  - at N: `rob_alloc` = 1, `ren_we` = 1 with rd 3 / tag 3;
  - at N+1: `out_valid_rs` = 1, vj = 5, vk = 7, `out_tag` = 3.
- **Capture bypass:** `rf_qj_busy` = 1, `rf_qj` = 2, with `cdb_valid[1]` = 1, tag 2, value 0x55 in the accept cycle → `out_qj_busy` = 0, `out_vj` = 0x55.
- **Hold snoop:**
  - Setup: load to LSB, `lsb_full` = 1 for 3 cycles, CDB tag 5 / value 0xAA in cycle 2 while qk = 5.
  - Response: `out_valid_lsb` stays 1; `dec_ready` = 0 while held (the held entry cannot dispatch); qk busy clears with vk = 0xAA; the entry dispatches when `lsb_full` drops.
- **ROB full:** `rob_full` = 1 with `dec_valid` = 1 for 4 cycles → `dec_ready` = 0, no `rob_alloc` or `ren_we`, `stall_rob_cnt` = 4.
- **Flush and x0 cases:**
  - `flush` with `hold_valid` = 1 and `dec_valid` = 1 → next cycle no out_valid and no alloc.
  - rd = x0 → `ren_we` = 0.
  - rs1 = x0 → vj = 0, not busy.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the Tomasulo core: default widths, operand and issue-entry structs.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ROB_W = 4;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  typedef struct packed {
    logic [XLEN-1:0]  v;
    logic [ROB_W-1:0] q;
    logic             busy;
  } operand_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [ROB_W-1:0] tag;
    logic             is_ls;
    operand_t         j;
    operand_t         k;
  } issue_entry_t;

  // A waiting operand picks up a broadcast value when its producer tag is seen.
  function automatic operand_t resolve(operand_t o, logic hit, logic [XLEN-1:0] val);
    operand_t r;
    r = o;
    if (o.busy && hit) begin
      r.v    = val;
      r.busy = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_cdb_match.sv
// CDB_N-way tag compare against one producer tag; the lowest matching channel wins.
module issue_cdb_match #(
  parameter int unsigned CDB_N = 2,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_tag,
  input  logic [CDB_N*XLEN-1:0]  cdb_value,
  input  logic [ROB_W-1:0]       q,
  output logic                   hit,
  output logic [XLEN-1:0]        value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int unsigned i = 0; i < CDB_N; i++) begin
      if (!hit && cdb_valid[i] && (cdb_tag[i*ROB_W +: ROB_W] == q)) begin
        hit   = 1'b1;
        value = cdb_value[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/issue_stage.sv
// One-entry registered issue stage: ROB allocation, rename, operand capture and CDB snoop.
// Optional stall counters are built when ISSUE_PERF_EN is defined.
module issue_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned ROB_W = riscv_pkg::ROB_W,
  parameter int unsigned REG_W = riscv_pkg::REG_W,
  parameter int unsigned OP_W  = riscv_pkg::OP_W,
  parameter int unsigned CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [XLEN-1:0]        dec_pc,
  input  logic [XLEN-1:0]        dec_imm,
  input  logic [OP_W-1:0]        dec_op,
  input  logic [REG_W-1:0]       dec_rd,
  input  logic [REG_W-1:0]       dec_rs1,
  input  logic [REG_W-1:0]       dec_rs2,
  input  logic                   dec_is_ls,
  input  logic                   rob_full,
  input  logic [ROB_W-1:0]       rob_tag,
  output logic                   rob_alloc,
  output logic [REG_W-1:0]       rf_rs1,
  output logic [REG_W-1:0]       rf_rs2,
  input  logic [XLEN-1:0]        rf_vj,
  input  logic [XLEN-1:0]        rf_vk,
  input  logic                   rf_qj_busy,
  input  logic                   rf_qk_busy,
  input  logic [ROB_W-1:0]       rf_qj,
  input  logic [ROB_W-1:0]       rf_qk,
  output logic                   ren_we,
  output logic [REG_W-1:0]       ren_rd,
  output logic [ROB_W-1:0]       ren_tag,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_tag,
  input  logic [CDB_N*XLEN-1:0]  cdb_value,
  input  logic                   rs_full,
  input  logic                   lsb_full,
  output logic                   out_valid_rs,
  output logic                   out_valid_lsb,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_vj,
  output logic [XLEN-1:0]        out_vk,
  output logic [OP_W-1:0]        out_op,
  output logic [REG_W-1:0]       out_rd,
  output logic [ROB_W-1:0]       out_tag,
  output logic [ROB_W-1:0]       out_qj,
  output logic [ROB_W-1:0]       out_qk,
  output logic                   out_qj_busy,
  output logic                   out_qk_busy
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]            stall_rob_cnt,
  output logic [31:0]            stall_disp_cnt
`endif
);

  logic         hold_valid;
  issue_entry_t entry;

  logic            cap_j_hit, cap_k_hit, hold_j_hit, hold_k_hit;
  logic [XLEN-1:0] cap_j_val, cap_k_val, hold_j_val, hold_k_val;
  operand_t        cap_j, cap_k, cur_j, cur_k;
  logic            disp_fire, accept;

  issue_cdb_match #(.CDB_N(CDB_N), .ROB_W(ROB_W), .XLEN(XLEN)) u_cap_j (
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .q(rf_qj), .hit(cap_j_hit), .value(cap_j_val)
  );
  issue_cdb_match #(.CDB_N(CDB_N), .ROB_W(ROB_W), .XLEN(XLEN)) u_cap_k (
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .q(rf_qk), .hit(cap_k_hit), .value(cap_k_val)
  );
  issue_cdb_match #(.CDB_N(CDB_N), .ROB_W(ROB_W), .XLEN(XLEN)) u_hold_j (
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .q(entry.j.q), .hit(hold_j_hit), .value(hold_j_val)
  );
  issue_cdb_match #(.CDB_N(CDB_N), .ROB_W(ROB_W), .XLEN(XLEN)) u_hold_k (
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .q(entry.k.q), .hit(hold_k_hit), .value(hold_k_val)
  );

  assign disp_fire = hold_valid & (entry.is_ls ? !lsb_full : !rs_full);
  assign dec_ready = !flush & !rob_full & (!hold_valid | disp_fire);
  assign accept    = dec_valid & dec_ready;

  assign rob_alloc = accept;
  assign ren_we    = accept & (dec_rd != '0);
  assign ren_rd    = dec_rd;
  assign ren_tag   = rob_tag;
  assign rf_rs1    = dec_rs1;
  assign rf_rs2    = dec_rs2;

  // x0 reads as a ready zero; otherwise a same-cycle broadcast beats the stale regfile tag.
  assign cap_j = (dec_rs1 == '0) ? '0
               : resolve(operand_t'{v: rf_vj, q: rf_qj, busy: rf_qj_busy}, cap_j_hit, cap_j_val);
  assign cap_k = (dec_rs2 == '0) ? '0
               : resolve(operand_t'{v: rf_vk, q: rf_qk, busy: rf_qk_busy}, cap_k_hit, cap_k_val);

  assign cur_j = resolve(entry.j, hold_j_hit, hold_j_val);
  assign cur_k = resolve(entry.k, hold_k_hit, hold_k_val);

  assign out_valid_rs  = hold_valid & !entry.is_ls;
  assign out_valid_lsb = hold_valid & entry.is_ls;
  assign out_pc        = entry.pc;
  assign out_imm       = entry.imm;
  assign out_op        = entry.op;
  assign out_rd        = entry.rd;
  assign out_tag       = entry.tag;
  assign out_vj        = cur_j.v;
  assign out_vk        = cur_k.v;
  assign out_qj        = cur_j.q;
  assign out_qk        = cur_k.q;
  assign out_qj_busy   = cur_j.busy;
  assign out_qk_busy   = cur_k.busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      entry      <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      entry      <= '{pc: dec_pc, op: dec_op, rd: dec_rd, imm: dec_imm, tag: rob_tag,
                      is_ls: dec_is_ls, j: cap_j, k: cap_k};
    end else begin
      if (disp_fire) hold_valid <= 1'b0;
      entry.j <= cur_j;
      entry.k <= cur_k;
    end
  end

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_rob_cnt  <= '0;
      stall_disp_cnt <= '0;
    end else begin
      if (dec_valid & rob_full & !flush)        stall_rob_cnt  <= stall_rob_cnt + 32'd1;
      if (hold_valid & !disp_fire & !flush)     stall_disp_cnt <= stall_disp_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Directed scenarios plus a randomized run against a behavioural model of the issue stage.
module tb_issue_stage;

  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int REG_W = 5;
  localparam int OP_W  = 6;
  localparam int CDB_N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, dec_valid, dec_ready, dec_is_ls, rob_full, rob_alloc;
  logic [XLEN-1:0] dec_pc, dec_imm, rf_vj, rf_vk;
  logic [OP_W-1:0] dec_op;
  logic [REG_W-1:0] dec_rd, dec_rs1, dec_rs2, rf_rs1, rf_rs2, ren_rd;
  logic [ROB_W-1:0] rob_tag, rf_qj, rf_qk, ren_tag;
  logic rf_qj_busy, rf_qk_busy, ren_we;
  logic [CDB_N-1:0] cdb_valid;
  logic [CDB_N*ROB_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0] cdb_value;
  logic rs_full, lsb_full, out_valid_rs, out_valid_lsb;
  logic [XLEN-1:0] out_pc, out_imm, out_vj, out_vk;
  logic [OP_W-1:0] out_op;
  logic [REG_W-1:0] out_rd;
  logic [ROB_W-1:0] out_tag, out_qj, out_qk;
  logic out_qj_busy, out_qk_busy;
`ifdef ISSUE_PERF_EN
  logic [31:0] stall_rob_cnt, stall_disp_cnt;
`endif

  int checks = 0;
  int errors = 0;

  issue_stage #(.XLEN(XLEN), .ROB_W(ROB_W), .REG_W(REG_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_imm(dec_imm),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_is_ls(dec_is_ls),
    .rob_full(rob_full), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_vj(rf_vj), .rf_vk(rf_vk),
    .rf_qj_busy(rf_qj_busy), .rf_qk_busy(rf_qk_busy), .rf_qj(rf_qj), .rf_qk(rf_qk),
    .ren_we(ren_we), .ren_rd(ren_rd), .ren_tag(ren_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rs_full(rs_full), .lsb_full(lsb_full),
    .out_valid_rs(out_valid_rs), .out_valid_lsb(out_valid_lsb),
    .out_pc(out_pc), .out_imm(out_imm), .out_vj(out_vj), .out_vk(out_vk),
    .out_op(out_op), .out_rd(out_rd), .out_tag(out_tag), .out_qj(out_qj), .out_qk(out_qk),
    .out_qj_busy(out_qj_busy), .out_qk_busy(out_qk_busy)
`ifdef ISSUE_PERF_EN
    , .stall_rob_cnt(stall_rob_cnt), .stall_disp_cnt(stall_disp_cnt)
`endif
  );

  task automatic idle();
    flush = 0; dec_valid = 0; dec_pc = '0; dec_imm = '0; dec_op = '0;
    dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_is_ls = 0;
    rob_full = 0; rob_tag = '0; rf_vj = '0; rf_vk = '0;
    rf_qj_busy = 0; rf_qk_busy = 0; rf_qj = '0; rf_qk = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0; rs_full = 0; lsb_full = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1; next_cycle();
    dec_valid = 1; dec_pc = 32'hDEAD; dec_rs1 = 1; rf_vj = 32'h77; rob_tag = 4'd9; rs_full = 1;
    next_cycle();
    dec_valid = 0; #1;
    checks++; if (out_valid_rs !== 1'b1) begin errors++; $display("FAIL reset_setup_hold: got %b want 1", out_valid_rs); end
    #2 rst_n = 0; #1;
    checks++; if (out_valid_rs !== 1'b0 || out_valid_lsb !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b%b want 00", out_valid_rs, out_valid_lsb); end
    checks++; if (out_pc !== '0 || out_vj !== '0 || out_tag !== '0 || out_qj_busy !== 1'b0) begin errors++; $display("FAIL reset_payload: pc %h vj %h tag %h want 0", out_pc, out_vj, out_tag); end
    next_cycle();
    rst_n = 1; rs_full = 0; #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready); end
`ifdef ISSUE_PERF_EN
    checks++; if (stall_rob_cnt !== 32'd0 || stall_disp_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d %0d want 0 0", stall_rob_cnt, stall_disp_cnt); end
`endif
    next_cycle();
  endtask

  task automatic test_basic_rs();
    idle();
    dec_valid = 1; dec_rd = 3; dec_rs1 = 1; dec_rs2 = 2; rf_vj = 5; rf_vk = 7; rob_tag = 3;
    dec_pc = 32'h100; dec_imm = 32'h20; dec_op = 6'h11; #1;
    checks++; if (rob_alloc !== 1'b1 || ren_we !== 1'b1) begin errors++; $display("FAIL basic_alloc: alloc %b we %b want 1 1", rob_alloc, ren_we); end
    checks++; if (ren_rd !== 5'd3 || ren_tag !== 4'd3) begin errors++; $display("FAIL basic_rename: rd %0d tag %0d want 3 3", ren_rd, ren_tag); end
    next_cycle();
    dec_valid = 0; #1;
    checks++; if (out_valid_rs !== 1'b1 || out_valid_lsb !== 1'b0) begin errors++; $display("FAIL basic_strobe: rs %b lsb %b want 1 0", out_valid_rs, out_valid_lsb); end
    checks++; if (out_vj !== 32'd5 || out_vk !== 32'd7 || out_tag !== 4'd3) begin errors++; $display("FAIL basic_payload: vj %0d vk %0d tag %0d want 5 7 3", out_vj, out_vk, out_tag); end
    checks++; if (out_pc !== 32'h100 || out_imm !== 32'h20 || out_op !== 6'h11 || out_rd !== 5'd3) begin errors++; $display("FAIL basic_fields: pc %h imm %h op %h rd %0d", out_pc, out_imm, out_op, out_rd); end
    next_cycle();
    checks++; if (out_valid_rs !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid_rs); end
  endtask

  task automatic test_capture_bypass();
    idle();
    dec_valid = 1; dec_rd = 4; dec_rs1 = 6; dec_rs2 = 7; rf_qj_busy = 1; rf_qj = 2; rf_vj = 32'h1111;
    rf_vk = 32'h22; rob_tag = 4'd6;
    cdb_valid = 2'b10; cdb_tag = {4'd2, 4'd0}; cdb_value = {32'h55, 32'h0};
    next_cycle();
    idle(); #1;
    checks++; if (out_qj_busy !== 1'b0 || out_vj !== 32'h55) begin errors++; $display("FAIL bypass_j: busy %b vj %h want 0 55", out_qj_busy, out_vj); end
    checks++; if (out_qk_busy !== 1'b0 || out_vk !== 32'h22) begin errors++; $display("FAIL bypass_k: busy %b vk %h want 0 22", out_qk_busy, out_vk); end
    next_cycle();
  endtask

  task automatic test_hold_snoop();
    idle();
    dec_valid = 1; dec_is_ls = 1; dec_rd = 8; dec_rs2 = 6; rf_qk_busy = 1; rf_qk = 5; rf_vk = 32'h999;
    rob_tag = 4'd11; lsb_full = 1;
    next_cycle();
    dec_is_ls = 0; dec_rd = 9; dec_rs2 = 1; rf_qk_busy = 0; rob_tag = 4'd12; #1;
    checks++; if (out_valid_lsb !== 1'b1 || out_qk_busy !== 1'b1 || out_qk !== 4'd5) begin errors++; $display("FAIL snoop_held: lsb %b busy %b qk %0d want 1 1 5", out_valid_lsb, out_qk_busy, out_qk); end
    checks++; if (dec_ready !== 1'b0 || rob_alloc !== 1'b0) begin errors++; $display("FAIL snoop_ready: ready %b alloc %b want 0 0", dec_ready, rob_alloc); end
    next_cycle();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_value = {32'h0, 32'hAA}; #1;
    checks++; if (out_qk_busy !== 1'b0 || out_vk !== 32'hAA) begin errors++; $display("FAIL snoop_forward: busy %b vk %h want 0 aa", out_qk_busy, out_vk); end
    next_cycle();
    cdb_valid = '0; #1;
    checks++; if (out_valid_lsb !== 1'b1 || out_qk_busy !== 1'b0 || out_vk !== 32'hAA) begin errors++; $display("FAIL snoop_latched: lsb %b busy %b vk %h want 1 0 aa", out_valid_lsb, out_qk_busy, out_vk); end
    next_cycle();
    lsb_full = 0; dec_valid = 0; #1;
    checks++; if (dec_ready !== 1'b1 || out_valid_lsb !== 1'b1) begin errors++; $display("FAIL snoop_release: ready %b lsb %b want 1 1", dec_ready, out_valid_lsb); end
    next_cycle();
    checks++; if (out_valid_lsb !== 1'b0) begin errors++; $display("FAIL snoop_dispatched: got %b want 0", out_valid_lsb); end
  endtask

  task automatic test_rob_full();
    idle();
    rst_n = 0; #2; rst_n = 1;
    next_cycle();
    dec_valid = 1; rob_full = 1; dec_rd = 5; dec_rs1 = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dec_ready !== 1'b0 || rob_alloc !== 1'b0 || ren_we !== 1'b0) begin errors++; $display("FAIL rob_full_c%0d: ready %b alloc %b we %b want 0", i, dec_ready, rob_alloc, ren_we); end
      next_cycle();
    end
    idle(); #1;
`ifdef ISSUE_PERF_EN
    checks++; if (stall_rob_cnt !== 32'd4) begin errors++; $display("FAIL rob_stall_cnt: got %0d want 4", stall_rob_cnt); end
`endif
    checks++; if (out_valid_rs !== 1'b0) begin errors++; $display("FAIL rob_full_noissue: got %b want 0", out_valid_rs); end
  endtask

  task automatic test_flush_x0();
    idle();
    dec_valid = 1; dec_rd = 2; dec_rs1 = 3; rs_full = 1; rob_tag = 4'd1;
    next_cycle();
    flush = 1; dec_rd = 4; rob_tag = 4'd2; #1;
    checks++; if (dec_ready !== 1'b0 || rob_alloc !== 1'b0 || ren_we !== 1'b0) begin errors++; $display("FAIL flush_cycle: ready %b alloc %b we %b want 0", dec_ready, rob_alloc, ren_we); end
    next_cycle();
    flush = 0; dec_valid = 0; #1;
    checks++; if (out_valid_rs !== 1'b0 || out_valid_lsb !== 1'b0) begin errors++; $display("FAIL flush_dropped: rs %b lsb %b want 0 0", out_valid_rs, out_valid_lsb); end
    idle();
    dec_valid = 1; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 4; rf_vj = 32'h1234; rf_qj_busy = 1; rf_qj = 7;
    rf_vk = 32'h44; rob_tag = 4'd3; #1;
    checks++; if (ren_we !== 1'b0 || rob_alloc !== 1'b1) begin errors++; $display("FAIL x0_rd: we %b alloc %b want 0 1", ren_we, rob_alloc); end
    next_cycle();
    idle(); #1;
    checks++; if (out_vj !== 32'd0 || out_qj_busy !== 1'b0 || out_vk !== 32'h44) begin errors++; $display("FAIL x0_rs1: vj %h busy %b vk %h want 0 0 44", out_vj, out_qj_busy, out_vk); end
    next_cycle();
  endtask

  function automatic void cdb_find(input logic [ROB_W-1:0] t, output bit f, output logic [XLEN-1:0] v);
    f = 0; v = '0;
    for (int i = 0; i < CDB_N; i++)
      if (!f && cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == t) begin
        f = 1; v = cdb_value[i*XLEN +: XLEN];
      end
  endfunction

  task automatic test_random(input int n);
    bit mv, mls, mjb, mkb, fire, e_ready, e_acc, hit, jb, kb;
    logic [XLEN-1:0] mpc, mimm, mvj, mvk, hv, jv, kv;
    logic [OP_W-1:0] mop;
    logic [REG_W-1:0] mrd;
    logic [ROB_W-1:0] mtag, mqj, mqk;
    int unsigned rob_cnt, disp_cnt;
    idle();
    rst_n = 0; #2; rst_n = 1;
    next_cycle();
    mv = 0; mls = 0; mjb = 0; mkb = 0; mpc = '0; mimm = '0; mvj = '0; mvk = '0;
    mop = '0; mrd = '0; mtag = '0; mqj = '0; mqk = '0; rob_cnt = 0; disp_cnt = 0;
    for (int c = 0; c < n; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      dec_valid = $urandom_range(0, 3) != 0;
      dec_pc = $urandom; dec_imm = $urandom; dec_op = OP_W'($urandom);
      dec_rd = REG_W'($urandom_range(0, 3)); dec_rs1 = REG_W'($urandom_range(0, 3));
      dec_rs2 = REG_W'($urandom_range(0, 3)); dec_is_ls = $urandom_range(0, 1);
      rob_full = ($urandom_range(0, 7) == 0); rob_tag = ROB_W'($urandom);
      rf_vj = $urandom; rf_vk = $urandom;
      rf_qj_busy = $urandom_range(0, 1); rf_qk_busy = $urandom_range(0, 1);
      rf_qj = ROB_W'($urandom_range(0, 3)); rf_qk = ROB_W'($urandom_range(0, 3));
      cdb_valid = CDB_N'($urandom);
      for (int i = 0; i < CDB_N; i++) begin
        cdb_tag[i*ROB_W +: ROB_W] = ROB_W'($urandom_range(0, 3));
        cdb_value[i*XLEN +: XLEN] = $urandom;
      end
      rs_full = ($urandom_range(0, 2) == 0); lsb_full = ($urandom_range(0, 2) == 0);
      #1;
      fire = mv && (mls ? !lsb_full : !rs_full);
      e_ready = !flush && !rob_full && (!mv || fire);
      e_acc = dec_valid && e_ready;
      jb = mjb; jv = mvj; cdb_find(mqj, hit, hv); if (jb && hit) begin jb = 0; jv = hv; end
      kb = mkb; kv = mvk; cdb_find(mqk, hit, hv); if (kb && hit) begin kb = 0; kv = hv; end
      checks++; if (dec_ready !== e_ready || rob_alloc !== e_acc) begin errors++; $display("FAIL rnd_hs c%0d: ready %b alloc %b want %b %b", c, dec_ready, rob_alloc, e_ready, e_acc); end
      checks++; if (ren_we !== (e_acc && dec_rd != 0) || (ren_we && (ren_rd !== dec_rd || ren_tag !== rob_tag))) begin errors++; $display("FAIL rnd_ren c%0d: we %b rd %0d tag %0d", c, ren_we, ren_rd, ren_tag); end
      checks++; if (out_valid_rs !== (mv && !mls) || out_valid_lsb !== (mv && mls)) begin errors++; $display("FAIL rnd_strobe c%0d: rs %b lsb %b want %b %b", c, out_valid_rs, out_valid_lsb, mv && !mls, mv && mls); end
      if (mv) begin
        checks++; if (out_pc !== mpc || out_imm !== mimm || out_op !== mop || out_rd !== mrd || out_tag !== mtag) begin errors++; $display("FAIL rnd_fields c%0d: pc %h tag %0d want %h %0d", c, out_pc, out_tag, mpc, mtag); end
        checks++; if (out_qj_busy !== jb || out_vj !== jv || (jb && out_qj !== mqj)) begin errors++; $display("FAIL rnd_j c%0d: busy %b v %h q %0d want %b %h %0d", c, out_qj_busy, out_vj, out_qj, jb, jv, mqj); end
        checks++; if (out_qk_busy !== kb || out_vk !== kv || (kb && out_qk !== mqk)) begin errors++; $display("FAIL rnd_k c%0d: busy %b v %h q %0d want %b %h %0d", c, out_qk_busy, out_vk, out_qk, kb, kv, mqk); end
      end
      if (dec_valid && rob_full && !flush) rob_cnt++;
      if (mv && !fire && !flush) disp_cnt++;
      if (flush) mv = 0;
      else if (e_acc) begin
        mv = 1; mpc = dec_pc; mimm = dec_imm; mop = dec_op; mrd = dec_rd; mtag = rob_tag; mls = dec_is_ls;
        mqj = rf_qj; mjb = rf_qj_busy; mvj = rf_vj; cdb_find(rf_qj, hit, hv);
        if (mjb && hit) begin mjb = 0; mvj = hv; end
        if (dec_rs1 == 0) begin mjb = 0; mvj = '0; end
        mqk = rf_qk; mkb = rf_qk_busy; mvk = rf_vk; cdb_find(rf_qk, hit, hv);
        if (mkb && hit) begin mkb = 0; mvk = hv; end
        if (dec_rs2 == 0) begin mkb = 0; mvk = '0; end
      end else begin
        if (fire) mv = 0;
        mjb = jb; mvj = jv; mkb = kb; mvk = kv;
      end
      next_cycle();
    end
    idle(); #1;
`ifdef ISSUE_PERF_EN
    checks++; if (stall_rob_cnt !== rob_cnt || stall_disp_cnt !== disp_cnt) begin errors++; $display("FAIL rnd_counters: got %0d %0d want %0d %0d", stall_rob_cnt, stall_disp_cnt, rob_cnt, disp_cnt); end
`endif
  endtask

  initial begin
    rst_n = 0;
    idle();
    #12;
    test_reset();
    test_basic_rs();
    test_capture_bypass();
    test_hold_snoop();
    test_rob_full();
    test_flush_x0();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, %0d checks made", checks);
    $fatal(1, "timeout");
  end

endmodule
